jk_sync_counter: RTL and testbench

Synchronous modulo-N up/down counter whose state bits are JK flip-flop stages operated in toggle mode, with a per-bit J/K excitation network as the upstream logic. It is the next stage up from the single JK flip-flop: the J/K driving logic and the flip-flop bank combined into a loadable counter. Downstream blocks use it as a BCD/decade counter or cascade it through `tc`.

---
 rtl/jk_sync_counter.sv | 85 ++++++++
 tb/tb_jk_sync_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter built from JK stages in toggle mode, driven by a per-bit J/K excitation network.
// Latency: 1 clock for count/load/clear; tc is combinational, wrap is a registered 1-cycle pulse; no backpressure.
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
        $error("jk_sync_counter: illegal WIDTH/MODULUS combination");
    end

    // Terminal value held one bit wider so MODULUS = 2^WIDTH compares correctly.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH-1:0] d_eff;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    always_comb begin
        q_ext = {1'b0, q_q};
        d_ext = {1'b0, d};
        d_eff = (d_ext > MAX_EXT) ? MAX_W : d;
        // An out-of-range state reached by a fault returns to 0 on the next up count.
        if (up) begin
            next_val = (q_ext >= MAX_EXT) ? '0 : q_q + ONE_W;
        end else begin
            next_val = (q_q == '0) ? MAX_W : q_q - ONE_W;
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (load) begin
            j = d_eff;
            k = ~d_eff;
        end else if (en) begin
            j = next_val ^ q_q;
            k = next_val ^ q_q;
        end
    end

    // Characteristic equation of each JK stage: Q+ = J&~Q | ~K&Q.
    always_comb begin
        q_d    = (j & ~q_q) | (~k & q_q);
        wrap_d = tc;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign tc   = en & ~load & ~clr & (up ? (q_ext == MAX_EXT) : (q_q == '0));
    assign q    = q_q;
    assign qbar = ~q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Randomised and directed bench for jk_sync_counter (MODULUS=10) plus a two-stage decade cascade.
module tb_jk_sync_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       clr, en, up, load;
    logic [3:0] d;
    logic [3:0] q, qbar;
    logic       tc, wrap;

    logic       hi_clr;
    logic [3:0] hi_q, hi_qbar;
    logic       hi_tc, hi_wrap;

    jk_sync_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
        .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(M)) hi (
        .clk(clk), .clr(hi_clr), .en(tc), .up(1'b1), .load(1'b0), .d(4'd0),
        .q(hi_q), .qbar(hi_qbar), .tc(hi_tc), .wrap(hi_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain modulo arithmetic on integers.
    int mq = 0, mwrap = 0, hq = 0, hwrap = 0;
    logic pre_tc_obs, pre_tc_exp;

    function automatic logic model_tc(int qv);
        return en && !load && !clr && (up ? (qv == M - 1) : (qv == 0));
    endfunction

    // Advance one clock: sample tc before the edge, update the model, return at the falling edge.
    task automatic tick();
        int lo_before;
        #1;
        pre_tc_obs = tc;
        pre_tc_exp = model_tc(mq);
        lo_before  = mq;
        @(posedge clk);
        if (clr) begin
            mq = 0; mwrap = 0;
        end else begin
            mwrap = pre_tc_exp ? 1 : 0;
            if (load)    mq = (int'(d) >= M) ? M - 1 : int'(d);
            else if (en) mq = up ? ((mq >= M - 1) ? 0 : mq + 1) : ((mq == 0) ? M - 1 : mq - 1);
        end
        if (hi_clr) begin
            hq = 0; hwrap = 0;
        end else begin
            hwrap = (pre_tc_exp && hq == M - 1) ? 1 : 0;
            if (pre_tc_exp) hq = (hq == M - 1) ? 0 : hq + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1; en = 1; load = 1; up = 1; d = 4'd7;
        tick(); tick();
        n_checks++;
        if (q !== 4'd0 || qbar !== 4'hF || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: q=%h qbar=%h wrap=%b, want q=0 qbar=F wrap=0", q, qbar, wrap);
        end
        n_checks++;
        if (pre_tc_obs !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tc: tc=%b want 0", pre_tc_obs);
        end
        clr = 0; en = 0; load = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (q !== 4'd0 || pre_tc_obs !== 1'b0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: q=%h tc=%b wrap=%b, want 0/0/0", i, q, pre_tc_obs, wrap);
            end
        end
    endtask

    task automatic test_up_wrap();
        int wraps = 0;
        en = 1; up = 1; load = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (q !== 4'((i + 1) % M) || pre_tc_obs !== (i % M == M - 1)) begin
                n_fail++;
                $display("FAIL up_wrap_%0d: q=%0d tc=%b, want q=%0d tc=%b", i, q, pre_tc_obs, (i + 1) % M, (i % M == M - 1));
            end
            n_checks++;
            if (wrap !== (i == 9)) begin
                n_fail++;
                $display("FAIL up_wrap_pulse_%0d: wrap=%b want %b", i, wrap, (i == 9));
            end
            wraps += int'(wrap);
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL up_wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_down_wrap();
        int exp_seq[4] = '{1, 0, 9, 8};
        int wraps = 0;
        load = 1; d = 4'd2; en = 1; tick(); load = 0;
        up = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (q !== 4'(exp_seq[i]) || pre_tc_obs !== (i == 2)) begin
                n_fail++;
                $display("FAIL down_wrap_%0d: q=%0d tc=%b, want q=%0d tc=%b", i, q, pre_tc_obs, exp_seq[i], (i == 2));
            end
            wraps += int'(wrap);
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL down_wrap_count: got %0d want 1", wraps);
        end
    endtask

    task automatic test_load_clamp();
        up = 1; en = 1; load = 1; d = 4'd6;
        tick();
        n_checks++;
        if (q !== 4'd6 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_6: q=%0d wrap=%b want 6/0", q, wrap);
        end
        d = 4'd13;
        tick();
        n_checks++;
        if (q !== 4'd9) begin
            n_fail++;
            $display("FAIL load_clamp: q=%0d want 9", q);
        end
        clr = 1; d = 4'd5;
        tick();
        clr = 0; load = 0;
        n_checks++;
        if (q !== 4'd0 || qbar !== 4'hF) begin
            n_fail++;
            $display("FAIL load_vs_clr: q=%0d qbar=%h want 0/F", q, qbar);
        end
    endtask

    task automatic test_dir_change();
        load = 1; d = 4'd9; tick(); load = 0;
        en = 1; up = 1;
        tick();
        n_checks++;
        if (q !== 4'd0 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_up_edge: q=%0d wrap=%b want 0/1", q, wrap);
        end
        up = 0;
        tick();
        n_checks++;
        if (q !== 4'd9 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_down_edge: q=%0d wrap=%b want 9/1", q, wrap);
        end
        en = 0;
        tick();
        n_checks++;
        if (q !== 4'd9 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_settle: q=%0d wrap=%b want 9/0", q, wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            d    = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (pre_tc_obs !== pre_tc_exp) begin
                n_fail++;
                $display("FAIL rand_tc_%0d: tc=%b want %b", i, pre_tc_obs, pre_tc_exp);
            end
            n_checks++;
            if (q !== 4'(mq) || qbar !== ~4'(mq) || wrap !== 1'(mwrap)) begin
                n_fail++;
                $display("FAIL rand_state_%0d: q=%0d qbar=%h wrap=%b want q=%0d qbar=%h wrap=%0d",
                         i, q, qbar, wrap, mq, ~4'(mq), mwrap);
            end
        end
        clr = 0; load = 0;
    endtask

    task automatic test_cascade();
        int hi_wraps = 0;
        clr = 1; hi_clr = 1; en = 1; up = 1; load = 0;
        tick();
        clr = 0; hi_clr = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_checks++;
            if (int'(hi_q) * M + int'(q) != (i + 1) % 100 || hi_qbar !== ~hi_q) begin
                n_fail++;
                $display("FAIL cascade_%0d: value=%0d%0d want %0d", i, hi_q, q, (i + 1) % 100);
            end
            hi_wraps += int'(hi_wrap);
        end
        n_checks++;
        if (hi_wraps != 1 || hi_wrap !== 1'(hwrap)) begin
            n_fail++;
            $display("FAIL cascade_wrap: upper pulses=%0d want 1", hi_wraps);
        end
    endtask

    initial begin
        clr = 1; en = 0; up = 1; load = 0; d = '0; hi_clr = 1;
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_dir_change();
        test_random();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
